// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants and FSM state encoding for the UART Tx path
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 868;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_e;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, tick marks the last clock of each bit
module uart_baud_cnt import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  // wrap to zero at the bit boundary, hold at zero while cleared
  always_comb begin
    tick = cnt_q == LAST;
    cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  end
  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequences start, 8 data bits LSB first and stop bit onto tx
module uart_tx_ctrl import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  state_e state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [2:0] bit_q, bit_d, bit_nx;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, tick;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE),
    .tick(tick)
  );
  // next-state logic; tx is computed one step ahead so it changes on the same edge as the state
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    bit_d = bit_q;
    bit_nx = bit_q + 3'd1;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          hold_d = data_in;
          state_d = START;
          tx_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
        tx_d = hold_q[0];
      end
      DATA: if (tick) begin
        if (bit_q == 3'(DATA_BITS - 1)) begin
          state_d = STOP;
          tx_d = 1'b1;
        end else begin
          bit_d = bit_nx;
          tx_d = hold_q[bit_nx];
        end
      end
      STOP: if (tick) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    endcase
  end
  // state and registered outputs; reset drops any frame in flight and idles the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      bit_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign tx = tx_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
